// File: rtl/restador4bit_serial.sv
// restador4bit_serial: bit-serial subtractor, one full-subtractor cell plus a
// borrow flip-flop, LSB first, under a start/busy/done handshake.
// Optional feature macro: RESTADOR_OVF_EN adds the signed-overflow output ov.
module restador4bit_serial #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] xi,
    input  logic [WIDTH-1:0] yi,
    output logic [WIDTH-1:0] zi,
    output logic             bo,
    output logic             busy,
    output logic             done
`ifdef RESTADOR_OVF_EN
    ,
    output logic             ov
`endif
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;
    logic [WIDTH-1:0] r_zi;
    logic [CW-1:0]    r_cnt;
    logic             r_b;
    logic             r_bo;
    logic             r_busy;
    logic             r_done;

    logic             w_accept;
    logic             w_shift;
    logic             w_last;
    logic             w_busy_nxt;
    logic             w_done_nxt;
    logic             w_d;
    logic             w_b_nxt;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: start is only honoured outside SHIFT
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_SHIFT;
            S_SHIFT: if (r_cnt == CW'(WIDTH - 1)) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = start ? S_SHIFT : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output/control decode: datapath strobes and next values of busy/done
    always_comb begin
        w_accept   = 1'b0;
        w_shift    = 1'b0;
        w_last     = 1'b0;
        w_busy_nxt = (w_state_nxt == S_SHIFT);
        w_done_nxt = (w_state_nxt == S_DONE);
        case (r_state)
            S_IDLE:  w_accept = start;
            S_SHIFT: begin
                w_shift = 1'b1;
                w_last  = (r_cnt == CW'(WIDTH - 1));
            end
            S_DONE:  w_accept = start;
            default: ;
        endcase
    end

    // Full-subtractor cell on the current LSBs of the operand registers
    always_comb begin
        w_d     = r_x[0] ^ r_y[0] ^ r_b;
        w_b_nxt = (~r_x[0] & r_y[0]) | (~(r_x[0] ^ r_y[0]) & r_b);
    end

    // Operand shift registers, bit counter, borrow FF and result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x   <= '0;
            r_y   <= '0;
            r_zi  <= '0;
            r_cnt <= '0;
            r_b   <= 1'b0;
            r_bo  <= 1'b0;
        end else if (w_accept) begin
            r_x   <= xi;
            r_y   <= yi;
            r_zi  <= '0;
            r_cnt <= '0;
            r_b   <= 1'b0;
            r_bo  <= 1'b0;
        end else if (w_shift) begin
            r_x   <= {1'b0, r_x[WIDTH-1:1]};
            r_y   <= {1'b0, r_y[WIDTH-1:1]};
            r_zi  <= {w_d, r_zi[WIDTH-1:1]};
            r_cnt <= r_cnt + CW'(1);
            r_b   <= w_b_nxt;
            if (w_last) begin
                r_bo <= w_b_nxt;
            end
        end
    end

    // Registered handshake flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
        end
    end

`ifdef RESTADOR_OVF_EN
    logic r_ov;

    // Signed overflow: operand signs differ and result sign differs from minuend
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ov <= 1'b0;
        end else if (w_accept) begin
            r_ov <= 1'b0;
        end else if (w_last) begin
            r_ov <= (r_x[0] ^ r_y[0]) & (w_d ^ r_x[0]);
        end
    end

    assign ov = r_ov;
`endif

    assign zi   = r_zi;
    assign bo   = r_bo;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_restador4bit_serial.sv
// Self-checking bench for restador4bit_serial: directed and random operands
// against an arithmetic reference model.
module tb_restador4bit_serial;

    localparam int unsigned W    = 4;
    localparam int unsigned MASK = (1 << W) - 1;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] xi;
    logic [W-1:0] yi;
    logic [W-1:0] zi;
    logic         bo;
    logic         busy;
    logic         done;
`ifdef RESTADOR_OVF_EN
    logic         ov;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    restador4bit_serial #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .xi    (xi),
        .yi    (yi),
        .zi    (zi),
        .bo    (bo),
        .busy  (busy),
        .done  (done)
`ifdef RESTADOR_OVF_EN
        ,
        .ov    (ov)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: plain modular arithmetic and sign rules
    task automatic check_result(input int x, input int y, input string tag);
        int exp_z;
        int exp_b;
        exp_z = (x - y) & MASK;
        exp_b = (x < y) ? 1 : 0;
        check({tag, "_zi"}, 32'(zi), 32'(exp_z));
        check({tag, "_bo"}, 32'(bo), 32'(exp_b));
`ifdef RESTADOR_OVF_EN
        begin
            int sx, sy, sz, exp_ov;
            sx = (x >> (W - 1)) & 1;
            sy = (y >> (W - 1)) & 1;
            sz = (exp_z >> (W - 1)) & 1;
            exp_ov = ((sx != sy) && (sz != sx)) ? 1 : 0;
            check({tag, "_ov"}, 32'(ov), 32'(exp_ov));
        end
`endif
    endtask

    // Counts negedges after an accepting edge until done; optionally pokes start mid-run
    task automatic wait_done(input bit poke, input string tag);
        int n;
        int nb;
        n  = 0;
        nb = 0;
        while (1) begin
            @(negedge clk);
            n++;
            if (busy) nb++;
            check({tag, "_excl"}, 32'(busy & done), 32'd0);
            if (poke && n == 2) begin
                start = 1'b1;
                xi    = W'($urandom);
                yi    = W'($urandom);
            end else if (poke && n == 3) begin
                start = 1'b0;
            end
            if (done) break;
            if (n >= 4 * W + 8) begin
                check({tag, "_timeout"}, 32'(done), 32'd1);
                break;
            end
        end
        check({tag, "_latency"}, 32'(n - 1), 32'(W));
        check({tag, "_busycyc"}, 32'(nb), 32'(W));
    endtask

    task automatic do_op(input int x, input int y, input bit poke, input string tag);
        @(negedge clk);
        start = 1'b1;
        xi    = W'(x);
        yi    = W'(y);
        @(posedge clk);
        #1;
        start = 1'b0;
        xi    = W'($urandom);
        yi    = W'($urandom);
        wait_done(poke, tag);
        check_result(x, y, tag);
        @(negedge clk);
        check({tag, "_donepulse"}, 32'(done), 32'd0);
        check({tag, "_hold"}, 32'(zi), 32'((x - y) & MASK));
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'($urandom);
        xi    = W'($urandom);
        yi    = W'($urandom);
        #12;
        check("rst_zi", 32'(zi), 32'd0);
        check("rst_bo", 32'(bo), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
`ifdef RESTADOR_OVF_EN
        check("rst_ov", 32'(ov), 32'd0);
`endif
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check("idle_done", 32'(done), 32'd0);
            check("idle_busy", 32'(busy), 32'd0);
        end

        do_op(9, 3, 1'b0, "d9m3");
        do_op(3, 9, 1'b0, "d3m9");
        do_op(15, 15, 1'b0, "dFmF");
        do_op(0, 1, 1'b0, "d0m1");
        do_op(8, 1, 1'b0, "d8m1");
        do_op(7, 1, 1'b0, "d7m1");
        do_op(5, 2, 1'b1, "poke");

        // Back-to-back: start held through the DONE cycle
        @(negedge clk);
        start = 1'b1;
        xi    = W'(5);
        yi    = W'(2);
        @(posedge clk);
        #1;
        xi = W'(2);
        yi = W'(5);
        wait_done(1'b0, "b2b1");
        check_result(5, 2, "b2b1");
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b_busy", 32'(busy), 32'd1);
        wait_done(1'b0, "b2b2");
        check_result(2, 5, "b2b2");
        @(negedge clk);
        check("b2b_idle", 32'(done), 32'd0);

        // Reset two cycles into 7-1
        @(negedge clk);
        start = 1'b1;
        xi    = W'(7);
        yi    = W'(1);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("mid_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_zi", 32'(zi), 32'd0);
        check("mid_bo", 32'(bo), 32'd0);
        check("mid_busy0", 32'(busy), 32'd0);
        check("mid_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            check("mid_nodone", 32'(done), 32'd0);
        end
        do_op(7, 1, 1'b0, "after_rst");

        // Random operands with random idle gaps and random mid-run start pokes
        for (int i = 0; i < 25; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            do_op(int'($urandom_range(0, MASK)), int'($urandom_range(0, MASK)),
                  1'($urandom_range(0, 1)), "rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
